// File: rtl/mantissa_normalizer.sv
// Post-add normalizer: carry right-shift or leading-zero left-shift, then exponent adjust.
// Two-stage valid/ready pipeline. Define MANTISSA_NORMALIZER_DENORM_EN for gradual underflow; the default flushes to zero.
module mantissa_normalizer (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic        in_sign,
  input  logic [7:0]  in_exp,
  input  logic [24:0] in_mant,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        out_sign,
  output logic [7:0]  out_exp,
  output logic [23:0] out_mant,
  output logic        out_inexact,
  output logic        out_ovf,
  output logic        out_unf,
  output logic        out_zero
);

  localparam int unsigned IN_W  = 25;
  localparam int unsigned OUT_W = 24;
  localparam int unsigned EXP_W = 8;
  localparam int unsigned LZ_W  = 5;

  logic               s1_valid;
  logic               s1_sign;
  logic               s1_carry;
  logic [EXP_W-1:0]   s1_exp;
  logic [IN_W-1:0]    s1_mant;
  logic [LZ_W-1:0]    s1_lz;

  logic               s1_adv_c;
  logic               s2_adv_c;
  logic [LZ_W-1:0]    lz_c;

  logic [EXP_W-1:0]   exp_c;
  logic [OUT_W-1:0]   mant_c;
  logic               inexact_c;
  logic               ovf_c;
  logic               unf_c;
  logic               zero_c;
  logic [EXP_W:0]     exp_inc_c;
`ifdef MANTISSA_NORMALIZER_DENORM_EN
  logic [LZ_W-1:0]    shift_c;
`endif

  assign s2_adv_c = !out_valid || out_ready;
  assign s1_adv_c = !s1_valid || s2_adv_c;
  assign in_ready = !s1_valid || !out_valid || out_ready;

  // Leading-zero count of in_mant[23:0]; highest set bit wins, 24 when all zero.
  always_comb begin
    lz_c = LZ_W'(24);
    for (int i = 0; i < 24; i++) begin
      if (in_mant[i]) lz_c = LZ_W'(23 - i);
    end
  end

  // Stage 1: capture operands with leading-zero count and carry flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_sign  <= 1'b0;
      s1_carry <= 1'b0;
      s1_exp   <= '0;
      s1_mant  <= '0;
      s1_lz    <= '0;
    end else if (s1_adv_c) begin
      s1_valid <= in_valid;
      if (in_valid) begin
        s1_sign  <= in_sign;
        s1_carry <= in_mant[24];
        s1_exp   <= in_exp;
        s1_mant  <= in_mant;
        s1_lz    <= lz_c;
      end
    end
  end

  // Stage 2 combinational: shift, exponent arithmetic and flag selection.
  always_comb begin
    exp_c     = '0;
    mant_c    = '0;
    inexact_c = 1'b0;
    ovf_c     = 1'b0;
    unf_c     = 1'b0;
    zero_c    = 1'b0;
    exp_inc_c = {1'b0, s1_exp} + 9'd1;
`ifdef MANTISSA_NORMALIZER_DENORM_EN
    shift_c   = '0;
`endif
    if (s1_carry) begin
      inexact_c = s1_mant[0];
      if (exp_inc_c >= 9'd255) begin
        exp_c = 8'hFF;
        ovf_c = 1'b1;
      end else begin
        exp_c  = exp_inc_c[EXP_W-1:0];
        mant_c = s1_mant[IN_W-1:1];
      end
    end else if (s1_mant[OUT_W-1:0] == '0) begin
      zero_c = 1'b1;
    end else if ({1'b0, s1_exp} > {4'b0, s1_lz}) begin
      mant_c = s1_mant[OUT_W-1:0] << s1_lz;
      exp_c  = s1_exp - {3'b0, s1_lz};
    end else begin
`ifdef MANTISSA_NORMALIZER_DENORM_EN
      // Shift only as far as exponent 1 allows; the result is stored with exponent 0.
      if (s1_exp != '0) shift_c = LZ_W'(s1_exp - 8'd1);
      mant_c = s1_mant[OUT_W-1:0] << shift_c;
      if (s1_exp == '0 && s1_mant[23]) begin
        exp_c = 8'd1;
      end else begin
        unf_c = 1'b1;
      end
`else
      unf_c = 1'b1;
`endif
    end
  end

  // Stage 2 registers: all outputs, held while stalled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid   <= 1'b0;
      out_sign    <= 1'b0;
      out_exp     <= '0;
      out_mant    <= '0;
      out_inexact <= 1'b0;
      out_ovf     <= 1'b0;
      out_unf     <= 1'b0;
      out_zero    <= 1'b0;
    end else if (s2_adv_c) begin
      out_valid <= s1_valid;
      if (s1_valid) begin
        out_sign    <= s1_sign;
        out_exp     <= exp_c;
        out_mant    <= mant_c;
        out_inexact <= inexact_c;
        out_ovf     <= ovf_c;
        out_unf     <= unf_c;
        out_zero    <= zero_c;
      end
    end
  end

endmodule

// File: tb/tb_mantissa_normalizer.sv
// Directed self-checking bench for mantissa_normalizer; follows MANTISSA_NORMALIZER_DENORM_EN if defined.
module tb_mantissa_normalizer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic        in_sign;
  logic [7:0]  in_exp;
  logic [24:0] in_mant;
  logic        out_valid;
  logic        out_ready;
  logic        out_sign;
  logic [7:0]  out_exp;
  logic [23:0] out_mant;
  logic        out_inexact;
  logic        out_ovf;
  logic        out_unf;
  logic        out_zero;

  typedef struct {
    logic [7:0]  e;
    logic [23:0] m;
    logic [4:0]  f;
    int          cyc;
    bit          lat;
  } exp_t;

  exp_t expq[$];
  int   cyc    = 0;
  int   n_chk  = 0;
  int   n_pass = 0;
  int   n_acc  = 0;

  mantissa_normalizer dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_sign(in_sign), .in_exp(in_exp), .in_mant(in_mant),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_sign(out_sign), .out_exp(out_exp), .out_mant(out_mant),
    .out_inexact(out_inexact), .out_ovf(out_ovf), .out_unf(out_unf), .out_zero(out_zero)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] want);
    n_chk++;
    if (obs === want) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, want);
  endtask

  // Called at a falling edge; returns at the falling edge after the beat is accepted.
  task automatic send(input logic s, input logic [7:0] e, input logic [24:0] m,
                      input logic [7:0] xe, input logic [23:0] xm, input logic [4:0] xf,
                      input bit lat);
    int   w;
    bit   ok;
    exp_t x;
    in_valid = 1'b1;
    in_sign  = s;
    in_exp   = e;
    in_mant  = m;
    w  = 0;
    ok = 1'b0;
    forever begin
      #4;
      ok    = in_ready;
      x.cyc = cyc;
      @(negedge clk);
      if (ok) break;
      w++;
      if (w > 50) begin
        check("send_timeout", 32'd0, 32'd1);
        break;
      end
    end
    if (ok) begin
      x.e   = xe;
      x.m   = xm;
      x.f   = xf;
      x.lat = lat;
      expq.push_back(x);
      n_acc++;
    end
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int w;
    w = 0;
    while (expq.size() != 0 && w < 100) begin
      @(negedge clk);
      w++;
    end
    check("drain", 32'(expq.size()), 32'd0);
  endtask

  // Output monitor: compares every handshaken result, in order, against the expected queue.
  initial begin : mon
    exp_t x;
    forever begin
      @(negedge clk);
      #4;
      if (rst_n && out_valid && out_ready) begin
        if (expq.size() == 0) begin
          check("extra_beat", 32'd1, 32'd0);
        end else begin
          x = expq.pop_front();
          check("out_exp", 32'(out_exp), 32'(x.e));
          check("out_mant", 32'(out_mant), 32'(x.m));
          check("flags", 32'({out_sign, out_inexact, out_ovf, out_unf, out_zero}), 32'(x.f));
          if (x.lat) check("latency", 32'(cyc - x.cyc), 32'd2);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int acc0;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_sign   = 1'b0;
    in_exp    = '0;
    in_mant   = '0;
    out_ready = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_exp", 32'(out_exp), 32'd0);
    check("rst_out_mant", 32'(out_mant), 32'd0);
    check("rst_flags", 32'({out_sign, out_inexact, out_ovf, out_unf, out_zero}), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    #1;
    check("rst_in_ready", 32'(in_ready), 32'd1);
    @(negedge clk);

    // Directed vectors at full throughput.
    out_ready = 1'b1;
    send(1'b0, 8'h80, 25'h1800001, 8'h81, 24'hC00000, 5'b01000, 1'b1);
    send(1'b0, 8'h90, 25'h0000300, 8'h82, 24'hC00000, 5'b00000, 1'b1);
    send(1'b1, 8'hFE, 25'h1000000, 8'hFF, 24'h000000, 5'b10100, 1'b1);
`ifdef MANTISSA_NORMALIZER_DENORM_EN
    send(1'b0, 8'h03, 25'h0000010, 8'h00, 24'h000040, 5'b00010, 1'b1);
`else
    send(1'b0, 8'h03, 25'h0000010, 8'h00, 24'h000000, 5'b00010, 1'b1);
`endif
    send(1'b1, 8'h55, 25'h0000000, 8'h00, 24'h000000, 5'b10001, 1'b1);
`ifdef MANTISSA_NORMALIZER_DENORM_EN
    send(1'b0, 8'h00, 25'h0800000, 8'h01, 24'h800000, 5'b00000, 1'b1);
    send(1'b0, 8'h15, 25'h0000004, 8'h00, 24'h400000, 5'b00010, 1'b1);
`else
    send(1'b0, 8'h00, 25'h0800000, 8'h00, 24'h000000, 5'b00010, 1'b1);
    send(1'b0, 8'h15, 25'h0000004, 8'h00, 24'h000000, 5'b00010, 1'b1);
`endif
    send(1'b0, 8'h16, 25'h0000004, 8'h01, 24'h800000, 5'b00000, 1'b1);
    send(1'b0, 8'hFD, 25'h1FFFFFF, 8'hFE, 24'hFFFFFF, 5'b01000, 1'b1);
    send(1'b1, 8'hFF, 25'h1000001, 8'hFF, 24'h000000, 5'b11100, 1'b1);
    send(1'b0, 8'h7F, 25'h0A00000, 8'h7F, 24'hA00000, 5'b00000, 1'b1);
    drain();

    // Backpressure: six beats while the sink stalls for four cycles.
    @(negedge clk);
    acc0 = n_acc;
    fork
      begin
        for (int i = 1; i <= 6; i++)
          send(1'b0, 8'(8'h40 + i), 25'(32'h800000 + i), 8'(8'h40 + i), 24'(32'h800000 + i), 5'b00000, 1'b0);
      end
      begin
        out_ready = 1'b0;
        repeat (3) @(negedge clk);
        #2;
        check("bp_hold_mant_a", 32'(out_mant), 32'h800001);
        @(negedge clk);
        #2;
        check("bp_hold_mant_b", 32'(out_mant), 32'h800001);
        check("bp_out_valid", 32'(out_valid), 32'd1);
        check("bp_in_ready", 32'(in_ready), 32'd0);
        check("bp_accepted", 32'(n_acc - acc0), 32'd2);
        #1;
        out_ready = 1'b1;
      end
    join
    drain();

    // Reset with both stages occupied.
    @(negedge clk);
    out_ready = 1'b0;
    send(1'b1, 8'h20, 25'h0800000, 8'h20, 24'h800000, 5'b10000, 1'b0);
    send(1'b1, 8'h21, 25'h0800000, 8'h21, 24'h800000, 5'b10000, 1'b0);
    #1;
    check("full_out_valid", 32'(out_valid), 32'd1);
    check("full_in_ready", 32'(in_ready), 32'd0);
    rst_n = 1'b0;
    #1;
    check("midrst_out_valid", 32'(out_valid), 32'd0);
    check("midrst_out_exp", 32'(out_exp), 32'd0);
    check("midrst_out_mant", 32'(out_mant), 32'd0);
    check("midrst_flags", 32'({out_sign, out_inexact, out_ovf, out_unf, out_zero}), 32'd0);
    expq.delete();
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("post_rst_in_ready", 32'(in_ready), 32'd1);
    @(negedge clk);
    out_ready = 1'b1;
    send(1'b0, 8'h10, 25'h0400000, 8'h0F, 24'h800000, 5'b00000, 1'b1);
    drain();
    repeat (5) @(negedge clk);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
